// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and constants for the SPI SRAM memory controller.
package spi_mem_ctrl_pkg;

    // Request from ctrl; the reserved code 2'b11 is handled like MEM_NOP.
    typedef enum logic [1:0] {
        MEM_NOP   = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_ctrl_op_e;

    // 23LC512 instruction bytes.
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    // Encoding chosen so bit 0 is set exactly in the two active-frame
    // states (SCK_LO, SCK_HI): chip select decodes from a single flop, and
    // the SCK_LO <-> SCK_HI toggle changes only bit 1.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        SCK_LO = 3'b001,
        SCK_HI = 3'b011,
        STOP   = 3'b010,
        DONE   = 3'b110
    } spi_mem_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register with serial in and serial out.
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] shreg_q;

    // Load has priority over shift; shifting moves toward the MSB.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= load_value;
        end else if (shift_en) begin
            shreg_q <= {shreg_q[WIDTH-2:0], serial_in};
        end
    end

    assign serial_out = shreg_q[WIDTH-1];
    assign value      = shreg_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// Single-byte SPI SRAM read/write engine (mode 0) sitting behind ctrl.
//
// Handshake with ctrl: mem_ctrl_op acts as "valid" and is sampled only
// while the FSM is IDLE; acceptance happens on the first IDLE edge that
// sees MEM_READ or MEM_WRITE. addr/data_in are captured at that edge and
// ignored afterwards. mem_op_done is a one-cycle completion strobe; ctrl
// must drop or change the op on seeing it, otherwise the op is accepted
// again on the IDLE cycle that follows DONE.
module spi_mem_ctrl
    import spi_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_BUS_WIDTH = 8,
    parameter int CLK_DIV        = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  mem_ctrl_op_e              mem_ctrl_op,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_BUS_WIDTH-1:0] data_in,
    output logic [DATA_BUS_WIDTH-1:0] data_out,
    output logic                      mem_op_done,
    output logic                      spi_cs_n,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output spi_mem_state_e            dbg_state
);

    // Frame = command byte, address, data byte (0x00 filler on reads).
    localparam int FRAME_W   = 8 + ADDR_WIDTH + DATA_BUS_WIDTH;
    localparam int BIT_CNT_W = $clog2(FRAME_W);
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT_IDX = BIT_CNT_W'(FRAME_W - 1);
    localparam logic [DIV_W-1:0]     DIV_LAST     = DIV_W'(CLK_DIV - 1);

    spi_mem_state_e state_q, state_d;

    logic [DIV_W-1:0]          div_cnt_q;
    logic [BIT_CNT_W-1:0]      bit_cnt_q;
    logic                      is_read_q;
    logic [DATA_BUS_WIDTH-1:0] data_out_q;

    logic                      is_req;
    logic                      accept;
    logic                      half_done;
    logic                      bit_end;
    logic                      last_bit;
    logic [7:0]                cmd_byte;
    logic [DATA_BUS_WIDTH-1:0] wr_byte;
    logic [FRAME_W-1:0]        frame_load;

    logic                      frame_msb;
    logic [FRAME_W-1:0]        frame_unused;
    logic                      rd_serial_unused;
    logic [DATA_BUS_WIDTH-1:0] rd_value;

    assign is_req    = (mem_ctrl_op == MEM_READ) || (mem_ctrl_op == MEM_WRITE);
    assign accept    = (state_q == IDLE) && is_req;
    assign half_done = (div_cnt_q == DIV_LAST);
    assign bit_end   = (state_q == SCK_HI) && half_done;
    assign last_bit  = (bit_cnt_q == '0);

    assign cmd_byte   = (mem_ctrl_op == MEM_READ) ? SPI_CMD_READ : SPI_CMD_WRITE;
    assign wr_byte    = (mem_ctrl_op == MEM_READ) ? '0 : data_in;
    assign frame_load = {cmd_byte, addr, wr_byte};

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SCK_LO/SCK_HI alternate every CLK_DIV cycles per bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCK_LO;
            SCK_LO:  if (half_done) state_d = SCK_HI;
            SCK_HI:  if (half_done) state_d = last_bit ? STOP : SCK_LO;
            STOP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Half-period divider; runs only inside the frame, restarts on each phase.
    always_ff @(posedge clock) begin
        if (!reset) begin
            div_cnt_q <= '0;
        end else if ((state_q == SCK_LO) || (state_q == SCK_HI)) begin
            div_cnt_q <= half_done ? '0 : div_cnt_q + 1'b1;
        end else begin
            div_cnt_q <= '0;
        end
    end

    // Remaining-bit counter and captured op direction.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bit_cnt_q <= '0;
            is_read_q <= 1'b0;
        end else if (accept) begin
            bit_cnt_q <= LAST_BIT_IDX;
            is_read_q <= (mem_ctrl_op == MEM_READ);
        end else if (bit_end && !last_bit) begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
        end
    end

    // Outgoing frame: loaded on acceptance, advanced at the end of each SCK high.
    spi_shift_reg #(
        .WIDTH (FRAME_W)
    ) u_frame_sr (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (frame_load),
        .shift_en   (bit_end),
        .serial_in  (1'b0),
        .serial_out (frame_msb),
        .value      (frame_unused)
    );

    // Incoming MISO bits; cleared on acceptance so aborted reads leave nothing.
    spi_shift_reg #(
        .WIDTH (DATA_BUS_WIDTH)
    ) u_read_sr (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value ('0),
        .shift_en   (bit_end),
        .serial_in  (spi_miso),
        .serial_out (rd_serial_unused),
        .value      (rd_value)
    );

    // Read result is registered on the STOP->DONE edge so it is valid with done.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_out_q <= '0;
        end else if ((state_q == STOP) && is_read_q) begin
            data_out_q <= rd_value;
        end
    end

    assign data_out    = data_out_q;
    assign mem_op_done = (state_q == DONE);
    assign spi_cs_n    = ~state_q[0];
    assign spi_sck     = (state_q == SCK_HI);
    assign spi_mosi    = state_q[0] ? frame_msb : 1'b0;
    assign dbg_state   = state_q;

endmodule
